// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs the ibus req/ack handshake.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// F_IDLE  | no fetch outstanding
// F_WAIT  | request on the bus, waiting for ack
// F_FULL  | fetched word parked in the buffer, waiting for load_ir
// F_DRAIN | request flushed by a PC update; swallow the ack
module fetch_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter logic [31:0]     NOP_INSN       = 32'h0000_0013,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_iaddr,
    input  logic            load_ir,
    input  logic            enable_pc_counter,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] ibus_addr,
    output logic            ibus_req,
    input  logic [31:0]     ibus_rdata,
    input  logic            ibus_ack,
    output logic [31:0]     ir,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            stall,
    output logic            misaligned,
    output logic            fetch_err
);

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_FULL, F_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] req_addr, req_addr_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [31:0]     ir_nxt;
    logic [31:0]     fetch_buf, fetch_buf_nxt;
    logic            misaligned_nxt;
    logic            stall_raw;
    logic            wd_expire;

`ifdef FETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] watchdog, watchdog_nxt;
    logic            waiting;

    assign waiting      = (state == F_WAIT || state == F_DRAIN) && !ibus_ack;
    assign wd_expire    = waiting && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign watchdog_nxt = (waiting && !wd_expire) ? watchdog + WD_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            watchdog  <= '0;
            fetch_err <= 1'b0;
        end else begin
            watchdog  <= watchdog_nxt;
            fetch_err <= fetch_err | wd_expire;
        end
    end

    // After a bus timeout the core runs the NOP in IR rather than hanging.
    assign stall = stall_raw & ~fetch_err;
`else
    assign wd_expire = 1'b0;
    assign fetch_err = 1'b0;
    assign stall     = stall_raw;
`endif

    assign ibus_addr = req_addr;
    assign ibus_req  = (state == F_WAIT) || (state == F_DRAIN);
    assign stall_raw = load_ir && !((state == F_FULL) || (state == F_WAIT && ibus_ack));
    assign opcode    = ir[6:0];
    assign next_pc   = pc + XLEN'(4);

    always_comb begin
        pc_nxt         = pc;
        misaligned_nxt = misaligned;
        if (enable_pc_counter) begin
            pc_nxt = pc_load ? {pc_target[XLEN-1:2], 2'b00} : next_pc;
            if (pc_load && (pc_target[1:0] != 2'b00))
                misaligned_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_addr_nxt  = req_addr;
        ir_nxt        = ir;
        fetch_buf_nxt = fetch_buf;
        case (state)
            F_IDLE: begin
                if (en_iaddr) begin
                    state_nxt    = F_WAIT;
                    req_addr_nxt = pc;
                end
            end
            F_WAIT: begin
                // A completing load wins over a same-cycle flush.
                if (ibus_ack) begin
                    if (load_ir) begin
                        ir_nxt    = ibus_rdata;
                        state_nxt = F_IDLE;
                    end else if (enable_pc_counter) begin
                        state_nxt = F_IDLE;
                    end else begin
                        fetch_buf_nxt = ibus_rdata;
                        state_nxt     = F_FULL;
                    end
                end else if (enable_pc_counter) begin
                    state_nxt = F_DRAIN;
                end
            end
            F_FULL: begin
                if (load_ir) begin
                    ir_nxt    = fetch_buf;
                    state_nxt = F_IDLE;
                end else if (enable_pc_counter) begin
                    state_nxt = F_IDLE;
                end
            end
            F_DRAIN: begin
                if (ibus_ack)
                    state_nxt = F_IDLE;
            end
            default: state_nxt = F_IDLE;
        endcase
        if (wd_expire) begin
            state_nxt = F_IDLE;
            ir_nxt    = NOP_INSN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= F_IDLE;
            pc         <= RESET_PC;
            ir         <= NOP_INSN;
            req_addr   <= RESET_PC;
            fetch_buf  <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ir         <= ir_nxt;
            req_addr   <= req_addr_nxt;
            fetch_buf  <= fetch_buf_nxt;
            misaligned <= misaligned_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus scoreboard,
// and a watchdog sequence that depends on FETCH_TIMEOUT_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_iaddr, load_ir, enable_pc_counter, pc_load;
    logic [31:0] pc_target;
    logic [31:0] ibus_addr;
    logic        ibus_req;
    logic [31:0] ibus_rdata;
    logic        ibus_ack;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [31:0] pc, next_pc;
    logic        stall, misaligned, fetch_err;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .en_iaddr(en_iaddr), .load_ir(load_ir),
        .enable_pc_counter(enable_pc_counter), .pc_load(pc_load), .pc_target(pc_target),
        .ibus_addr(ibus_addr), .ibus_req(ibus_req), .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack),
        .ir(ir), .opcode(opcode), .pc(pc), .next_pc(next_pc),
        .stall(stall), .misaligned(misaligned), .fetch_err(fetch_err)
    );

    typedef struct {
        string       name;
        logic        rst, en, ld, epc, pl;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req, e_stall;     // before the edge
        logic [31:0] e_addr;             // before the edge
        logic [31:0] e_ir, e_pc;         // after the edge
        logic        e_mis;              // after the edge
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic r, input logic en, input logic ld,
                                input logic epc, input logic pl, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rd,
                                input logic ereq, input logic estall, input logic [31:0] eaddr,
                                input logic [31:0] eir, input logic [31:0] epcv, input logic emis);
        vec_t v;
        v.name = nm; v.rst = r; v.en = en; v.ld = ld; v.epc = epc; v.pl = pl; v.tgt = tgt;
        v.ack = ack; v.rdata = rd; v.e_req = ereq; v.e_stall = estall; v.e_addr = eaddr;
        v.e_ir = eir; v.e_pc = epcv; v.e_mis = emis;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.rst; en_iaddr = v.en; load_ir = v.ld; enable_pc_counter = v.epc;
        pc_load = v.pl; pc_target = v.tgt; ibus_ack = v.ack; ibus_rdata = v.rdata;
    endtask

    task automatic drive_idle(input logic r);
        rst = r; en_iaddr = 0; load_ir = 0; enable_pc_counter = 0;
        pc_load = 0; pc_target = 0; ibus_ack = 0; ibus_rdata = 0;
    endtask

    initial begin
        vec_t e;
        int   cnt;
        //                   name   rst en ld epc pl target        ack rdata         req stl addr          ir            pc            mis
        vecs.push_back(mk("t1_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00000013, 32'h0,        0));
        vecs.push_back(mk("t1_ack",  1, 0, 1, 0, 0, 32'h0,        1, 32'h00500093, 1, 0, 32'h0,        32'h00500093, 32'h0,        0));
        vecs.push_back(mk("t2_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00500093, 32'h0,        0));
        vecs.push_back(mk("t2_w1",   1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00500093, 32'h0,        0));
        vecs.push_back(mk("t2_w2",   1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00500093, 32'h0,        0));
        vecs.push_back(mk("t2_w3",   1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        32'h00500093, 32'h0,        0));
        vecs.push_back(mk("t2_ack",  1, 0, 1, 0, 0, 32'h0,        1, 32'h00a00113, 1, 0, 32'h0,        32'h00a00113, 32'h0,        0));
        vecs.push_back(mk("t2_idle", 1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00a00113, 32'h0,        0));
        vecs.push_back(mk("t3_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00a00113, 32'h0,        0));
        vecs.push_back(mk("t3_ack",  1, 0, 0, 0, 0, 32'h0,        1, 32'h00c00193, 1, 0, 32'h0,        32'h00a00113, 32'h0,        0));
        vecs.push_back(mk("t3_full", 1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00a00113, 32'h0,        0));
        vecs.push_back(mk("t3_load", 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'h0,        0));
        vecs.push_back(mk("t3_istl", 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h00c00193, 32'h0,        0));
        vecs.push_back(mk("t4_jmax", 1, 0, 0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'hFFFFFFFC, 0));
        vecs.push_back(mk("t4_wrap", 1, 0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'h0,        0));
        vecs.push_back(mk("t4_mis",  1, 0, 0, 1, 1, 32'h00000102, 0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'h00000100, 1));
        vecs.push_back(mk("t4_stk",  1, 0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'h00000104, 1));
        vecs.push_back(mk("t5_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00c00193, 32'h00000104, 1));
        vecs.push_back(mk("t5_fls",  1, 0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h00000104, 32'h00c00193, 32'h00000108, 1));
        vecs.push_back(mk("t5_drn",  1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h00000104, 32'h00c00193, 32'h00000108, 1));
        vecs.push_back(mk("t5_dack", 1, 0, 0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h00000104, 32'h00c00193, 32'h00000108, 1));
        vecs.push_back(mk("t5_istl", 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00000104, 32'h00c00193, 32'h00000108, 1));
        vecs.push_back(mk("t5_req2", 1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000104, 32'h00c00193, 32'h00000108, 1));
        vecs.push_back(mk("t5_rst",  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h00000108, 32'h00000013, 32'h0,        0));
        vecs.push_back(mk("t5_late", 1, 0, 1, 0, 0, 32'h0,        1, 32'h11111111, 0, 1, 32'h0,        32'h00000013, 32'h0,        0));
        vecs.push_back(mk("sl_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00000013, 32'h0,        0));
        vecs.push_back(mk("sl_both", 1, 0, 1, 1, 0, 32'h0,        1, 32'h00100213, 1, 0, 32'h0,        32'h00100213, 32'h00000004, 0));
        vecs.push_back(mk("sl_idle", 1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00100213, 32'h00000004, 0));
        vecs.push_back(mk("ff_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h00100213, 32'h00000004, 0));
        vecs.push_back(mk("ff_ack",  1, 0, 0, 0, 0, 32'h0,        1, 32'h0BADC0DE, 1, 0, 32'h00000004, 32'h00100213, 32'h00000004, 0));
        vecs.push_back(mk("ff_fls",  1, 0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000004, 32'h00100213, 32'h00000008, 0));
        vecs.push_back(mk("ff_istl", 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00000004, 32'h00100213, 32'h00000008, 0));
        vecs.push_back(mk("wa_req",  1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h00000004, 32'h00100213, 32'h00000008, 0));
        vecs.push_back(mk("wa_fls",  1, 0, 0, 1, 0, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h00000008, 32'h00100213, 32'h0000000C, 0));
        vecs.push_back(mk("wa_istl", 1, 0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h00000008, 32'h00100213, 32'h0000000C, 0));

        drive_idle(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_idle(1'b1);
        #1;
        chk("rst ibus_req", 32'(ibus_req), 32'h0);
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst ibus_addr", ibus_addr, 32'h0);
        chk("rst pc", pc, 32'h0);
        chk("rst next_pc", next_pc, 32'h4);
        chk("rst ir", ir, 32'h00000013);
        chk("rst opcode", 32'(opcode), 32'h13);
        chk("rst misaligned", 32'(misaligned), 32'h0);
        chk("rst fetch_err", 32'(fetch_err), 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            chk({e.name, " ibus_req"}, 32'(ibus_req), 32'(e.e_req));
            chk({e.name, " stall"}, 32'(stall), 32'(e.e_stall));
            chk({e.name, " ibus_addr"}, ibus_addr, e.e_addr);
            @(posedge clk);
            #1;
            chk({e.name, " ir"}, ir, e.e_ir);
            chk({e.name, " opcode"}, 32'(opcode), {25'b0, e.e_ir[6:0]});
            chk({e.name, " pc"}, pc, e.e_pc);
            chk({e.name, " next_pc"}, next_pc, e.e_pc + 32'd4);
            chk({e.name, " misaligned"}, 32'(misaligned), 32'(e.e_mis));
            chk({e.name, " fetch_err"}, 32'(fetch_err), 32'h0);
        end

        // Watchdog: a request that is never acked.
        @(negedge clk);
        drive_idle(1'b0);
        @(negedge clk);
        drive_idle(1'b1);
        en_iaddr = 1;
        @(negedge clk);
        en_iaddr = 0;
        load_ir  = 1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!ibus_req) break;
            cnt++;
            @(negedge clk);
        end
`ifdef FETCH_TIMEOUT_EN
        chk("wd req cycles", 32'(cnt), 32'd16);
        chk("wd ibus_req", 32'(ibus_req), 32'h0);
        chk("wd fetch_err", 32'(fetch_err), 32'h1);
        chk("wd ir", ir, 32'h00000013);
        chk("wd stall", 32'(stall), 32'h0);
`else
        chk("nowd req cycles", 32'(cnt), 32'd40);
        chk("nowd ibus_req", 32'(ibus_req), 32'h1);
        chk("nowd stall", 32'(stall), 32'h1);
        chk("nowd fetch_err", 32'(fetch_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC and the instruction register (IR), and runs the instruction-bus req/ack handshake.
- Feeds `opcode` to the control unit and returns `stall` to it.
- Sequenced by the control unit's `en_iaddr`, `load_ir` and `enable_pc_counter` strobes.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSN, 32'h0000_0013, IR value after reset (addi x0,x0,0).
- TIMEOUT_CYCLES, 16, ack watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low; sampled on posedge clk only.
- en_iaddr  in  1  control unit requests an address-out/fetch.
- load_ir  in  1  control unit wants IR loaded this cycle.
- enable_pc_counter  in  1  PC update strobe (execute cycle).
- pc_load  in  1  take pc_target instead of pc+4.
- pc_target  in  XLEN  jump/branch target from ALU.
- ibus_addr  out  XLEN  instruction bus address.
- ibus_req  out  1  instruction bus request.
- ibus_rdata  in  32  instruction bus read data, valid when ibus_ack.
- ibus_ack  in  1  instruction bus acknowledge; may be asserted in the same cycle as req.
- ir  out  32  instruction register.
- opcode  out  7  ir[6:0].
- pc  out  XLEN  current PC.
- next_pc  out  XLEN  pc+4; destination value for jal/jalr.
- stall  out  1  freeze request to the control unit.
- misaligned  out  1  sticky: misaligned target taken.
- fetch_err  out  1  sticky: bus timeout; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
Reset (rst==0 at posedge) sets:
- pc=RESET_PC, ir=NOP_INSN, req_addr=RESET_PC, buf=0.
- state=F_IDLE, misaligned=0, fetch_err=0, watchdog=0.
- Outputs combinationally derived from these registers, so after reset: ibus_req=0, stall=0.
- A reset in any state, including F_WAIT with an outstanding request, returns to F_IDLE. A late ack is then ignored because state is F_IDLE.

FSM states:
- F_IDLE:
  - en_iaddr=1 → F_WAIT, req_addr<=pc.
- F_WAIT (ibus_req=1, ibus_addr=req_addr):
  - ack & load_ir → F_IDLE, ir<=ibus_rdata (bypass, zero stall).
  - ack & !load_ir → F_FULL, buf<=ibus_rdata.
  - !ack → stay.
- F_FULL:
  - load_ir → F_IDLE, ir<=buf.
  - else hold.
- F_DRAIN (ibus_req=1, ibus_addr=req_addr):
  - ack → F_IDLE, data discarded.

Common rules:
- ibus_addr=req_addr in every state; ibus_req=1 only in F_WAIT and F_DRAIN.
- stall = load_ir & !(state==F_FULL | (state==F_WAIT & ibus_ack)).
  - Covers load_ir in F_IDLE and F_DRAIN, which also stall.
- PC update on enable_pc_counter:
  - pc_load=1 → pc<=pc_target & ~3.
  - pc_load=0 → pc<=pc+4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Misaligned target: if pc_load & pc_target[1:0]!=0, misaligned<=1 (sticky until reset).
- Flush:
  - enable_pc_counter in F_FULL → F_IDLE, buf dropped.
  - enable_pc_counter in F_WAIT without ack → F_DRAIN.
  - enable_pc_counter in F_WAIT with ack → F_IDLE, data dropped, ir unchanged.
- Simultaneous load_ir & enable_pc_counter: the load completes first (IR updated), the PC still updates, and the state ends in F_IDLE.
- opcode=ir[6:0]; next_pc=pc+4 (combinational).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - watchdog counts cycles in F_WAIT/F_DRAIN with ibus_ack=0, and clears on ack or on leaving those states.
  - When watchdog reaches TIMEOUT_CYCLES: fetch_err<=1 (sticky), state → F_IDLE, ibus_req drops, ir<=NOP_INSN.
  - stall is forced 0 from the following cycle, so the core executes a NOP instead of hanging.
- Undefined: no counter is built, fetch_err=0, and F_WAIT waits indefinitely.

Test Plan:
1. Reset, then en_iaddr=1 for one cycle, then load_ir=1, with a memory that acks in the same cycle as req and returns 32'h00500093 → ir=32'h00500093, opcode=7'b0010011, stall=0 throughout, ibus_addr=0.
2. Memory acks 3 cycles after req, with load_ir held → stall=1 for exactly 3 cycles, ir loaded on the ack cycle, state F_IDLE afterwards.
3. Ack arrives one cycle before load_ir → data buffered (F_FULL), next load_ir yields stall=0 and ir=buffered word.
4. enable_pc_counter with pc_load=0 at pc=32'hFFFF_FFFC → pc=0; with pc_load=1 and pc_target=32'h0000_0102 → pc=32'h100, misaligned=1 and it stays 1.
5. enable_pc_counter while a request is pending (ack 2 cycles later) → F_DRAIN, ibus_req held, ack data discarded, ir unchanged; then rst=0 mid-F_WAIT → ibus_req=0 next cycle, pc=RESET_PC, ir=NOP_INSN.
6. With FETCH_TIMEOUT_EN and no ack ever → fetch_err=1 after 16 cycles in F_WAIT, ibus_req=0, ir=32'h00000013.
